// File: rtl/ex_operand_stage.sv
// ID/EX operand stage: resolves forwarded register values, selects PC/immediate
// operands, inserts load-use bubbles and registers everything for the execute ALU.
module ex_operand_stage #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         flush,
  input  logic         dec_valid,
  output logic         dec_ready,
  input  logic [4:0]   dec_rs1,
  input  logic [4:0]   dec_rs2,
  input  logic [N-1:0] dec_rs1_data,
  input  logic [N-1:0] dec_rs2_data,
  input  logic [N-1:0] dec_imm,
  input  logic [N-1:0] dec_pc,
  input  logic         dec_use_pc,
  input  logic         dec_use_imm,
  input  logic         dec_alu_s,
  input  logic [4:0]   dec_rd,
  input  logic         dec_we,
  input  logic         dec_is_load,
  input  logic         dec_is_branch,
  input  logic [4:0]   mem_rd,
  input  logic         mem_we,
  input  logic [N-1:0] mem_data,
  input  logic [4:0]   wb_rd,
  input  logic         wb_we,
  input  logic [N-1:0] wb_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic         alu_s,
  output logic [4:0]   ex_rd,
  output logic         ex_we,
  output logic         ex_is_load,
  output logic         ex_is_branch,
  output logic [N-1:0] ex_pc,
  output logic [N-1:0] ex_imm,
  output logic [N-1:0] ex_rs2_val,
  output logic [15:0]  bubble_cnt
);

  // x0 is hardwired zero; MEM is younger than WB so it wins.
  function automatic logic [N-1:0] fwd_val(
    input logic [4:0]   idx,
    input logic [N-1:0] rf_val,
    input logic         m_we,
    input logic [4:0]   m_rd,
    input logic [N-1:0] m_data,
    input logic         w_we,
    input logic [4:0]   w_rd,
    input logic [N-1:0] w_data
  );
    logic [N-1:0] v;
    if (idx == 5'd0) begin
      v = {N{1'b0}};
    end else if (m_we && (m_rd == idx)) begin
      v = m_data;
    end else if (w_we && (w_rd == idx)) begin
      v = w_data;
    end else begin
      v = rf_val;
    end
    return v;
  endfunction

  logic         out_valid_r;
  logic [N-1:0] alu_a_r;
  logic [N-1:0] alu_b_r;
  logic         alu_s_r;
  logic [4:0]   ex_rd_r;
  logic         ex_we_r;
  logic         ex_is_load_r;
  logic         ex_is_branch_r;
  logic [N-1:0] ex_pc_r;
  logic [N-1:0] ex_imm_r;
  logic [N-1:0] ex_rs2_val_r;
  logic [15:0]  bubble_cnt_r;

  logic [N-1:0] rs1_fwd_s;
  logic [N-1:0] rs2_fwd_s;
  logic         hazard_s;
  logic         stall_s;
  logic         dec_ready_s;

  assign rs1_fwd_s = fwd_val(dec_rs1, dec_rs1_data, mem_we, mem_rd, mem_data, wb_we, wb_rd, wb_data);
  assign rs2_fwd_s = fwd_val(dec_rs2, dec_rs2_data, mem_we, mem_rd, mem_data, wb_we, wb_rd, wb_data);

  // Hazard detection and decode-side handshake; rs2 is checked even for immediates.
  always_comb begin
    hazard_s    = 1'b0;
    stall_s     = out_valid_r && !out_ready;
    dec_ready_s = 1'b0;
    if (out_valid_r && ex_is_load_r && ex_we_r && (ex_rd_r != 5'd0) && dec_valid) begin
      hazard_s = ((ex_rd_r == dec_rs1) && !dec_use_pc) || (ex_rd_r == dec_rs2);
    end else begin
      hazard_s = 1'b0;
    end
    dec_ready_s = flush || (!hazard_s && !stall_s);
  end

  // Pipeline register: reset, flush, hold, bubble, accept, drain in that priority.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid_r    <= 1'b0;
      alu_a_r        <= {N{1'b0}};
      alu_b_r        <= {N{1'b0}};
      alu_s_r        <= 1'b0;
      ex_rd_r        <= 5'd0;
      ex_we_r        <= 1'b0;
      ex_is_load_r   <= 1'b0;
      ex_is_branch_r <= 1'b0;
      ex_pc_r        <= {N{1'b0}};
      ex_imm_r       <= {N{1'b0}};
      ex_rs2_val_r   <= {N{1'b0}};
      bubble_cnt_r   <= 16'd0;
    end else if (flush) begin
      out_valid_r <= 1'b0;
    end else if (stall_s) begin
      out_valid_r <= out_valid_r;
    end else if (hazard_s) begin
      out_valid_r <= 1'b0;
      if (bubble_cnt_r != 16'hFFFF) begin
        bubble_cnt_r <= bubble_cnt_r + 16'd1;
      end
    end else if (dec_valid && dec_ready_s) begin
      out_valid_r    <= 1'b1;
      alu_a_r        <= dec_use_pc  ? dec_pc  : rs1_fwd_s;
      alu_b_r        <= dec_use_imm ? dec_imm : rs2_fwd_s;
      alu_s_r        <= dec_alu_s;
      ex_rd_r        <= dec_rd;
      ex_we_r        <= dec_we;
      ex_is_load_r   <= dec_is_load;
      ex_is_branch_r <= dec_is_branch;
      ex_pc_r        <= dec_pc;
      ex_imm_r       <= dec_imm;
      ex_rs2_val_r   <= rs2_fwd_s;
    end else begin
      out_valid_r <= 1'b0;
    end
  end

  assign dec_ready    = dec_ready_s;
  assign out_valid    = out_valid_r;
  assign alu_a        = alu_a_r;
  assign alu_b        = alu_b_r;
  assign alu_s        = alu_s_r;
  assign ex_rd        = ex_rd_r;
  assign ex_we        = ex_we_r;
  assign ex_is_load   = ex_is_load_r;
  assign ex_is_branch = ex_is_branch_r;
  assign ex_pc        = ex_pc_r;
  assign ex_imm       = ex_imm_r;
  assign ex_rs2_val   = ex_rs2_val_r;
  assign bubble_cnt   = bubble_cnt_r;

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline stage of the RV32I core: sits directly upstream of the execute ALU and registers its two operands and function select. It resolves the true register values by forwarding from MEM and WB, and selects PC or immediate operands. It detects load-use hazards and inserts a one-cycle bubble, and supports back-pressure and flush through a valid/ready handshake on both sides.

## Interface
- N, 32, data/operand width
- clk  in  1  clock, all state updates on rising edge
- rstn  in  1  synchronous active-low reset
- flush  in  1  kill stage contents (branch taken / redirect)
- dec_valid  in  1  decode offers an instruction
- dec_ready  out  1  stage accepts this cycle
- dec_rs1, dec_rs2  in  5  source register indices
- dec_rs1_data, dec_rs2_data  in  N  register-file read data
- dec_imm, dec_pc  in  N  immediate, instruction PC
- dec_use_pc  in  1  ALU a = PC instead of rs1
- dec_use_imm  in  1  ALU b = imm instead of rs2
- dec_alu_s  in  1  ALU function: 0 = ADD, 1 = CMP (xor)
- dec_rd  in  5  destination; dec_we  in  1  writes rd
- dec_is_load, dec_is_branch  in  1  instruction class
- mem_rd  in  5; mem_we  in  1; mem_data  in  N  MEM-stage forward source
- wb_rd  in  5; wb_we  in  1; wb_data  in  N  WB-stage forward source
- out_valid  out  1  ALU operands valid
- out_ready  in  1  execute stage accepts
- alu_a, alu_b  out  N  registered operands
- alu_s  out  1  registered function select
- ex_rd  out  5; ex_we, ex_is_load, ex_is_branch  out  1; ex_pc, ex_imm  out  N  sideband carried to EX
- ex_rs2_val  out  N  forwarded rs2 value (store data / branch)
- bubble_cnt  out  16  saturating count of load-use bubbles

## Operation
- Forwarding, per source s in {rs1, rs2}: index 0 → value 0, never forwarded. Else mem_we && mem_rd==s → mem_data. Else wb_we && wb_rd==s → wb_data. Else register-file data. MEM has priority over WB.
- Operand select: a = use_pc ? dec_pc : fwd(rs1); b = use_imm ? dec_imm : fwd(rs2); ex_rs2_val = fwd(rs2) always.
- Load-use hazard: out_valid && ex_is_load && ex_we && ex_rd≠0 && dec_valid && (ex_rd==dec_rs1 && !dec_use_pc, or ex_rd==dec_rs2). rs2 is checked even when use_imm is set, as a conservative check.
- dec_ready = flush | (!hazard && (!out_valid | out_ready)).
- Register update, in priority order:
  - !rstn: all outputs 0, bubble_cnt 0.
  - flush: out_valid←0. The offered decode beat is consumed (dec_ready=1) and discarded. Other registers may hold.
  - out_valid && !out_ready: hold every output register unchanged.
  - hazard: out_valid←0 (bubble). The decode beat is held (dec_ready=0). bubble_cnt += 1, saturating at 0xFFFF.
  - dec_valid && dec_ready: load all output registers from the selected values; out_valid←1.
  - Otherwise: out_valid←0.
- After one bubble, the load is in MEM and mem_data carries its load data, so the next cycle forwards from MEM. One bubble is always sufficient.
- No arithmetic on data; all operand paths are width N, unmodified.

## Timing
- Latency 1 cycle: beat accepted at edge k appears on alu_a/alu_b/out_valid after edge k.
- Full throughput: one instruction per cycle while out_ready=1 and no hazard.
- Forwarding is combinational from mem_*/wb_* in the accept cycle. Values are sampled at the accept edge only; held outputs never re-forward.
- dec_ready is combinational from out_valid, out_ready, flush and the hazard check.
- flush during a stall (out_valid && !out_ready): the flush wins and out_valid=0 next cycle.
- Reset mid-stream: the next cycle shows out_valid=0, alu_a=alu_b=0, bubble_cnt=0. No in-flight beat survives.

## Test plan
- Plain accept: rs1=3 (data 0x10), rs2=4 (data 0x20), no forward matches, alu_s=0 → next cycle out_valid=1, alu_a=0x10, alu_b=0x20, alu_s=0.
- Forward priority: rs1=5, mem_rd=5 with mem_data=0xAAAA, wb_rd=5 with wb_data=0xBBBB, both we=1 → alu_a=0xAAAA. With mem_we=0 → alu_a=0xBBBB. With rs1=0 and matching forwards → alu_a=0.
- Load-use: a load to rd=7 is in the stage, then an instruction with rs2=7 is offered. Required: dec_ready=0 for 1 cycle, out_valid=0 for that cycle, bubble_cnt=1. The next cycle it is accepted with alu_b=mem_data.
- Back-pressure: out_ready=0 for 3 cycles with out_valid=1 → outputs constant, dec_ready=0. Then out_ready=1 → the next beat is accepted that cycle.
- Flush: flush=1 with dec_valid=1 and a stalled valid output → dec_ready=1, next cycle out_valid=0, bubble_cnt unchanged.
- Immediate/PC select: use_pc=1, use_imm=1, pc=0x100, imm=0xFFFFFFFC → alu_a=0x100, alu_b=0xFFFFFFFC, ex_rs2_val = forwarded rs2.
